mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that acts as the responder on the processor's data-memory load/store interface. It sits beside data memory in the single-cycle top and is selected by address decode. Stores push bytes into a TX FIFO and program the baud divisor. Loads return status with combinational read data, so the single-cycle core never sees a wait state. Serialises 8N1 frames on the `tx` pin.

Parameters:
BASE_ADDR, 32'h0000_1000, base of the 16-byte register window; bits [3:0] must be zero.
FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2.
DEFAULT_DIV, 16'd867, reset value of the baud divisor; bit period is DIV+1 clocks.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous active-low reset.
A  input  32  byte address from the core.
WD  input  32  write data.
WE  input  1  store strobe; the write commits at the rising edge.
RD  output  32  combinational read data; 0 when not selected.
tx  output  1  serial line; idles high.

Behaviour:
- Address decode: selected when A[31:4] == BASE_ADDR[31:4]. The offset is A[3:0].
- Offset 0x0: TXDATA.
  - A write pushes WD[7:0].
  - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and the overflow flag is set.
  - Reads return 0.
- Offset 0x4: STATUS (read).
  - bit0 busy (FSM not in IDLE), bit1 fifo_full, bit2 fifo_empty, bit3 overflow (sticky).
  - Other bits read 0.
  - Writing 1 to bit3 clears overflow. If an overflow occurs in the same cycle, set wins.
- Offset 0x8: BAUDDIV. R/W, bits [15:0]; upper bits read 0.
- Offset 0xC: reserved. Reads 0; writes are ignored.
- Reset values (rst low, asynchronous):
  - tx=1, FSM=IDLE, FIFO empty (pointers and count 0), overflow=0, div=DEFAULT_DIV, shift register=0, bit counter=0, baud counter=0.
  - RD stays combinational, so after reset STATUS reads 0x4.
- FIFO: synchronous.
  - A push and a pop in the same cycle are both accepted, even when the FIFO is full.
  - Pointers wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits wide.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop into the shift register, latch div into frame_div, and go to START. tx=0 from that edge.
  - START: tx=0 for frame_div+1 clocks, then DATA.
  - DATA: send 8 bits LSB first, each for frame_div+1 clocks; 3-bit counter. After bit 7 go to STOP.
  - STOP: tx=1 for frame_div+1 clocks. At the end, if the FIFO is non-empty, pop directly into START (back-to-back, no idle cycle); otherwise go to IDLE.
- Latency: a store at edge N with the FIFO empty and FSM in IDLE gives tx falling at edge N+1. A frame is exactly 10*(div+1) clocks.
- A BAUDDIV write mid-frame takes effect at the next frame start only.
- DIV=0 is legal: 1 clock per bit.
- Reset mid-frame aborts the frame immediately: tx=1 and queued bytes are lost.

Optional Feature:
Macro UART_TX_IRQ_EN.
- When defined:
  - Adds output port `irq` (1 bit, reset 0), registered.
  - irq = irq_en & fifo_empty & ~busy, where irq_en is bit0 of offset 0xC (R/W, reset 0).
- When undefined:
  - No irq port.
  - Offset 0xC stays reserved (reads 0, writes ignored).

Decomposition:
- Package uart_tx_pkg holds:
  - register offset constants OFF_TXDATA=4'h0, OFF_STATUS=4'h4, OFF_BAUDDIV=4'h8, OFF_CTRL=4'hC;
  - STATUS bit index constants;
  - the FSM state enum typedef (2 bits).
- One sub-module, sync_fifo: parameterised width 8 and depth FIFO_DEPTH, with push/pop/full/empty/count. It is reusable by a future UART RX.

Test Plan:
- Reset, then read 0x1004 -> RD=0x4, tx=1. Read 0x1008 -> RD=867.
- Write BAUDDIV=3, then TXDATA=0x55.
  - tx falls one edge later.
  - Line carries 0,1,0,1,0,1,0,1,0,1, each held 4 clocks; 40 clocks total.
  - busy clears only after the stop bit.
- DIV=0, write 0xA5 then 0x3C on consecutive cycles -> two frames back-to-back, 20 clocks, no idle gap between stop and start.
- FIFO_DEPTH=8, DIV=1000, write 10 bytes in 10 cycles.
  - The first is popped after one cycle, so 9 are stored.
  - The 10th is dropped; STATUS reads full=1, overflow=1.
  - Writing 0x8 to STATUS clears overflow.
- Assert rst low mid DATA bit 3 -> tx=1 asynchronously; STATUS=0x4 after release; no further frame.
- With UART_TX_IRQ_EN: set CTRL=1, send one byte -> irq=0 during the frame, then irq=1 the cycle after the FSM returns to IDLE.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the memory-mapped UART transmitter.
//   - register offsets inside the 16-byte window
//   - STATUS bit positions
//   - transmit FSM state encoding
package uart_tx_pkg;

  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_BAUDDIV = 4'h8;
  localparam logic [3:0] OFF_CTRL    = 4'hC;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO shared by the UART transmit path (and a
// future receive path).
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset (pointers and count only)
//   push   write din this cycle; accepted when not full, or when full and
//          a pop happens in the same cycle
//   din    write data (DATA_W bits)
//   pop    remove the head entry; ignored when empty
//   dout   head entry, combinational
//   full   count == DEPTH
//   empty  count == 0
//   count  occupancy, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
  import uart_tx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the core's data
// load/store port. Reads are combinational so the single-cycle core never
// stalls.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   A     byte address; selected when A[31:4] == BASE_ADDR[31:4]
//   WD    store data
//   WE    store strobe, commits on the rising edge
//   RD    load data, 0 when not selected
//   tx    serial line, idles high
//   irq   (only with UART_TX_IRQ_EN) registered "transmitter drained" flag
// Register window: 0x0 TXDATA (W), 0x4 STATUS, 0x8 BAUDDIV, 0xC CTRL/reserved.
// Optional feature macro: UART_TX_IRQ_EN adds CTRL.irq_en and the irq port.
module mmio_uart_tx
  import uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  output logic        tx
`ifdef UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  logic                         sel;
  logic [3:0]                   off;
  logic                         wr_tx;
  logic                         wr_stat;
  logic                         wr_div;
  logic [15:0]                  div;
  logic                         ovf;
  logic                         busy;

  logic                         fifo_pop;
  logic [7:0]                   fifo_dout;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;

  tx_state_t                    state, state_n;
  logic [7:0]                   shreg, shreg_n;
  logic [2:0]                   bitcnt, bitcnt_n;
  logic [15:0]                  baudcnt, baudcnt_n;
  logic [15:0]                  frame_div, frame_div_n;
  logic                         bit_end;

  assign sel     = (A[31:4] == BASE_ADDR[31:4]);
  assign off     = A[3:0];
  assign wr_tx   = WE && sel && (off == OFF_TXDATA);
  assign wr_stat = WE && sel && (off == OFF_STATUS);
  assign wr_div  = WE && sel && (off == OFF_BAUDDIV);
  assign busy    = (state != ST_IDLE);

  logic unused_bits;
  assign unused_bits = ^{WD[31:16], fifo_count};

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_tx),
    .din   (WD[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Register file: baud divisor and sticky overflow (set beats clear)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= DEFAULT_DIV;
      ovf <= 1'b0;
    end else begin
      if (wr_div) div <= WD[15:0];
      if (wr_tx && fifo_full && !fifo_pop) ovf <= 1'b1;
      else if (wr_stat && WD[STAT_OVF])    ovf <= 1'b0;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_en;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (WE && sel && (off == OFF_CTRL)) irq_en <= WD[0];
      irq <= irq_en && fifo_empty && !busy;
    end
  end
`endif

  always_comb begin
    RD = '0;
    if (sel) begin
      case (off)
        OFF_STATUS: begin
          RD[STAT_BUSY]  = busy;
          RD[STAT_FULL]  = fifo_full;
          RD[STAT_EMPTY] = fifo_empty;
          RD[STAT_OVF]   = ovf;
        end
        OFF_BAUDDIV: RD = {16'd0, div};
`ifdef UART_TX_IRQ_EN
        OFF_CTRL:    RD = {31'd0, irq_en};
`endif
        default:     RD = '0;
      endcase
    end
  end

  // Transmit FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      baudcnt   <= '0;
      frame_div <= '0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bitcnt    <= bitcnt_n;
      baudcnt   <= baudcnt_n;
      frame_div <= frame_div_n;
    end
  end

  // Transmit FSM: next state and line output. Loading from the FIFO in
  // STOP goes straight to START so consecutive frames have no idle gap.
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    bitcnt_n    = bitcnt;
    baudcnt_n   = baudcnt;
    frame_div_n = frame_div;
    fifo_pop    = 1'b0;
    tx          = 1'b1;
    bit_end     = (baudcnt == frame_div);
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          shreg_n     = fifo_dout;
          frame_div_n = div;
          baudcnt_n   = '0;
          state_n     = ST_START;
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (bit_end) begin
          baudcnt_n = '0;
          bitcnt_n  = '0;
          state_n   = ST_DATA;
        end else begin
          baudcnt_n = baudcnt + 16'd1;
        end
      end
      ST_DATA: begin
        tx = shreg[0];
        if (bit_end) begin
          baudcnt_n = '0;
          shreg_n   = {1'b0, shreg[7:1]};
          if (bitcnt == 3'd7) state_n  = ST_STOP;
          else                bitcnt_n = bitcnt + 3'd1;
        end else begin
          baudcnt_n = baudcnt + 16'd1;
        end
      end
      ST_STOP: begin
        tx = 1'b1;
        if (bit_end) begin
          baudcnt_n = '0;
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            shreg_n     = fifo_dout;
            frame_div_n = div;
            state_n     = ST_START;
          end else begin
            state_n     = ST_IDLE;
          end
        end else begin
          baudcnt_n = baudcnt + 16'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench for mmio_uart_tx. Inputs change and
// outputs are sampled around the falling clock edge.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] A   = '0;
  logic [31:0] WD  = '0;
  logic        WE  = 1'b0;
  logic [31:0] RD;
  logic        tx;
`ifdef UART_TX_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR   (32'h0000_1000),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd867)
  ) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .WD  (WD),
    .WE  (WE),
    .RD  (RD),
    .tx  (tx)
`ifdef UART_TX_IRQ_EN
    ,
    .irq (irq)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Line level of an 8N1 frame at bit slot idx (0 start, 1..8 data LSB first, 9 stop)
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Called at a falling edge; the store commits on the next rising edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    A  = a;
    WD = d;
    WE = 1'b1;
    @(posedge clk);
    @(negedge clk);
    WE = 1'b0;
    WD = '0;
    A  = '0;
  endtask

  task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
    A = a;
    #1;
    chk(tag, RD, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;

    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("tx_in_reset", {31'd0, tx}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rd(32'h1004, "status_reset", 32'h4);
    chk("tx_idle", {31'd0, tx}, 32'd1);
    rd(32'h1008, "div_reset", 32'd867);
    rd(32'h100C, "ctrl_reset", 32'h0);
    rd(32'h1000, "txdata_reads_zero", 32'h0);
    rd(32'h2004, "unselected_zero", 32'h0);

    // DIV=3, single byte 0x55: 40-clock frame
    wr(32'h1008, 32'd3);
    rd(32'h1008, "div_written", 32'd3);
    wr(32'h1000, 32'h55);
    chk("tx_before_start", {31'd0, tx}, 32'd1);
    A = 32'h1004;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk($sformatf("f55_clk%0d", i), {31'd0, tx}, {31'd0, frame_bit(8'h55, i / 4)});
      if (i == 39) chk("busy_in_stop", {31'd0, RD[0]}, 32'd1);
    end
    @(negedge clk);
    chk("tx_after_f55", {31'd0, tx}, 32'd1);
    rd(32'h1004, "status_after_f55", 32'h4);

    // DIV=0, two bytes on consecutive cycles: back-to-back frames
    wr(32'h1008, 32'd0);
    A  = 32'h1000;
    WD = 32'hA5;
    WE = 1'b1;
    @(posedge clk);
    @(negedge clk);
    WD = 32'h3C;
    @(posedge clk);
    @(negedge clk);
    WE = 1'b0;
    A  = 32'h1004;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 10) chk($sformatf("fA5_clk%0d", i), {31'd0, tx}, {31'd0, frame_bit(8'hA5, i)});
      else        chk($sformatf("f3C_clk%0d", i), {31'd0, tx}, {31'd0, frame_bit(8'h3C, i - 10)});
      if (i == 10) chk("b2b_busy", {31'd0, RD[0]}, 32'd1);
    end
    @(negedge clk);
    chk("tx_after_b2b", {31'd0, tx}, 32'd1);
    rd(32'h1004, "status_after_b2b", 32'h4);

    // Overflow: 10 stores in 10 cycles, FIFO depth 8
    wr(32'h1008, 32'd1000);
    A  = 32'h1000;
    WE = 1'b1;
    for (int i = 0; i < 10; i++) begin
      WD = 32'h10 + i;
      @(posedge clk);
      @(negedge clk);
    end
    WE = 1'b0;
    rd(32'h1004, "status_overflow", 32'hB);
    wr(32'h1004, 32'h8);
    rd(32'h1004, "status_ovf_cleared", 32'h3);
    rd(32'h1008, "div_1000", 32'd1000);
`ifndef UART_TX_IRQ_EN
    wr(32'h100C, 32'h1);
    rd(32'h100C, "reserved_write_ignored", 32'h0);
`endif

    // Clean reset, then reset asserted during DATA bit 3
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rd(32'h1004, "status_after_reset1", 32'h4);
    rd(32'h1008, "div_after_reset1", 32'd867);
    wr(32'h1008, 32'd3);
    wr(32'h1000, 32'h00);
    wr(32'h1000, 32'h00);
    repeat (17) @(negedge clk);
    chk("tx_data_bit3_low", {31'd0, tx}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("tx_async_reset", {31'd0, tx}, 32'd1);
    rd(32'h1004, "status_in_reset", 32'h4);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) cnt++;
    end
    chk("no_frame_after_reset", cnt, 32'd0);
    rd(32'h1004, "status_after_reset2", 32'h4);

`ifdef UART_TX_IRQ_EN
    // Interrupt: low during the frame, high one cycle after return to IDLE
    wr(32'h100C, 32'h1);
    rd(32'h100C, "ctrl_irq_en", 32'h1);
    wr(32'h1008, 32'd1);
    wr(32'h1000, 32'h5A);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (irq !== 1'b0) cnt++;
    end
    chk("irq_low_in_frame", cnt, 32'd0);
    @(negedge clk);
    chk("irq_low_at_idle_entry", {31'd0, irq}, 32'd0);
    rd(32'h1004, "status_idle_irq", 32'h4);
    @(negedge clk);
    chk("irq_high_after_idle", {31'd0, irq}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
